mhsa_launch_ctrl: RTL and testbench
===================================

MHSA_LAUNCH_CTRL -- requirements
Module: mhsa_launch_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, SoC address width.
REQ-002 The block SHALL have parameter DATA_W, default 64, SoC data word width.
REQ-003 The block SHALL have parameter LEN_W, default 16, job length field width, in words.
REQ-004 The block SHALL have these ports, one per line:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid / cmd_ready  in / out  1 / 1  job command handshake.
- cmd_in_base, cmd_out_base  in  ADDR_W  input and output buffer base addresses.
- cmd_in_len, cmd_out_len  in  LEN_W  number of words to load and to drain.
- ld_valid / ld_ready / ld_data  in / out / in  1 / 1 / DATA_W  input word stream.
- start  out  1  accelerator launch.
- done  in  1  accelerator completion.
- input_base, output_base  out  ADDR_W  bases presented to the accelerator.
- soc_write_en  out  1  SoC buffer write strobe.
- soc_addr  out  ADDR_W  SoC buffer address.
- soc_data_in  out  DATA_W  SoC buffer write data.
- soc_data_out  in  DATA_W  SoC buffer read data.
- rd_valid / rd_ready / rd_data  out / in / out  1 / 1 / DATA_W  result stream.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 The FSM SHALL have four states: IDLE, LOAD, RUN, DRAIN; reset state is IDLE.
REQ-006 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&&cmd_ready, the block SHALL latch all cmd fields and drive input_base/output_base from them.
REQ-007 On accept, the FSM SHALL go to LOAD if cmd_in_len!=0, else directly to RUN.
REQ-008 In LOAD, ld_ready SHALL be 1; each ld_valid&&ld_ready cycle SHALL assert soc_write_en in the same cycle, with soc_addr=in_base+idx, soc_data_in=ld_data, idx=0..in_len-1.
REQ-009 After the write with idx=in_len-1, the FSM SHALL go to RUN on the next edge.
REQ-010 On RUN entry, start SHALL rise on the entry edge and stay 1 until done is sampled 1.
REQ-011 On the edge done is sampled 1 in RUN, start SHALL fall, and the FSM SHALL go to DRAIN if out_len!=0, else to IDLE; done outside RUN SHALL be ignored.
REQ-012 In DRAIN, the block SHALL drive soc_addr=out_base+idx with soc_write_en=0, then capture soc_data_out exactly one cycle later into rd_data with rd_valid=1.
REQ-013 rd_data/rd_valid SHALL hold until rd_ready; the next read address SHALL issue in the cycle after the handshake (one word per two cycles minimum).
REQ-014 After the rd handshake of word out_len-1, the FSM SHALL return to IDLE.
REQ-015 input_base/output_base SHALL change only on command accept and stay constant through LOAD, RUN and DRAIN.
REQ-016 Address arithmetic SHALL be modulo 2^ADDR_W (base+idx wraps silently); idx SHALL be a LEN_W-bit counter cleared on each state entry.
REQ-017 When not writing, soc_write_en SHALL be 0 and soc_data_in SHALL be all-zero; no output SHALL ever be X after reset.
REQ-018 ld_ready SHALL be 0 outside LOAD; rd_valid SHALL be 0 outside DRAIN.

Reset
REQ-019 Asserting rst_n low at any time, including mid-job, SHALL immediately force: state IDLE; start, soc_write_en, ld_ready, rd_valid, busy = 0; cmd_ready = 0 while rst_n is low and 1 from the first edge after release; all address, data and base outputs = 0.
REQ-020 After release, no partial job SHALL resume; the next command SHALL start fresh.

Structure
REQ-021 Package mhsa_ctrl_pkg SHALL hold the state enum and the default ADDR_W/DATA_W/LEN_W constants.
REQ-022 The read-capture and hold path SHALL be a sub-module mhsa_rd_buf (one-entry valid/ready holding register).

Verification
REQ-023 Job in_base=0x0100, in_len=4, out_base=0x0200, out_len=2 -> writes to 0x0100..0x0103 in order; start high until done; two rd words from 0x0200 and 0x0201; busy low afterwards.
REQ-024 in_len=0, out_len=0 -> IDLE->RUN->IDLE; no soc_write_en, no rd_valid; start asserted for exactly the cycles until done.
REQ-025 in_base=0xFFFE, in_len=3 -> write addresses 0xFFFE, 0xFFFF, 0x0000.
REQ-026 rd_ready held low 5 cycles during DRAIN -> rd_data stable, soc_addr not advanced, no word lost.
REQ-027 rst_n pulsed low during RUN -> start=0 asynchronously, state IDLE; a new job then completes normally.
REQ-028 done pulsed while in IDLE or LOAD -> no state change; start not affected.

Source files
------------

// File: rtl/mhsa_ctrl_pkg.sv
// Shared state encoding and default widths for the MHSA launch controller.
// Pure declarations: no logic, no latency, no flow control.
package mhsa_ctrl_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_LEN_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/mhsa_rd_buf.sv
// One-entry holding register for result words; loads in one cycle when empty.
// Holds data stable until o_out_vld && i_out_rdy; refuses new input while full.
module mhsa_rd_buf #(
    parameter int DATA_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_vld,
    output logic              o_in_rdy,
    input  logic [DATA_W-1:0] i_in_dat,
    output logic              o_out_vld,
    input  logic              i_out_rdy,
    output logic [DATA_W-1:0] o_out_dat
);

    logic              r_vld;
    logic [DATA_W-1:0] r_dat;

    // No flow-through: the next fetch waits for the cycle after the pop.
    assign o_in_rdy  = ~r_vld;
    assign o_out_vld = r_vld;
    assign o_out_dat = r_dat;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (i_in_vld && o_in_rdy) begin
            r_vld <= 1'b1;
            r_dat <= i_in_dat;
        end else if (r_vld && i_out_rdy) begin
            r_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/mhsa_launch_ctrl.sv
// Job sequencer: load input words into SoC buffer, launch accelerator, drain results.
// Writes same-cycle as ld handshake; reads take one cycle into a held rd buffer (>=2 cycles/word).
module mhsa_launch_ctrl
    import mhsa_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_in_base,
    input  logic [ADDR_W-1:0] cmd_out_base,
    input  logic [LEN_W-1:0]  cmd_in_len,
    input  logic [LEN_W-1:0]  cmd_out_len,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    output logic              start,
    input  logic              done,
    output logic [ADDR_W-1:0] input_base,
    output logic [ADDR_W-1:0] output_base,
    output logic              soc_write_en,
    output logic [ADDR_W-1:0] soc_addr,
    output logic [DATA_W-1:0] soc_data_in,
    input  logic [DATA_W-1:0] soc_data_out,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_cmd_en;
    logic [ADDR_W-1:0] r_in_base;
    logic [ADDR_W-1:0] r_out_base;
    logic [LEN_W-1:0]  r_in_len;
    logic [LEN_W-1:0]  r_out_len;
    logic [LEN_W-1:0]  r_idx;

    logic w_cmd_hs;
    logic w_ld_hs;
    logic w_rd_hs;
    logic w_last_wr;
    logic w_last_rd;
    logic w_buf_rdy;
    logic w_rd_issue;

    assign w_cmd_hs   = cmd_valid & r_cmd_en & (r_state == ST_IDLE);
    assign w_ld_hs    = ld_valid & (r_state == ST_LOAD);
    assign w_rd_hs    = rd_valid & rd_ready;
    assign w_last_wr  = w_ld_hs & (r_idx == r_in_len - LEN_W'(1));
    assign w_last_rd  = w_rd_hs & (r_idx == r_out_len - LEN_W'(1));
    assign w_rd_issue = (r_state == ST_DRAIN) & w_buf_rdy;

    assign input_base  = r_in_base;
    assign output_base = r_out_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        cmd_ready    = 1'b0;
        ld_ready     = 1'b0;
        start        = 1'b0;
        busy         = 1'b1;
        soc_write_en = 1'b0;
        soc_addr     = '0;
        soc_data_in  = '0;
        case (r_state)
            ST_IDLE: begin
                busy      = 1'b0;
                cmd_ready = r_cmd_en;
                if (w_cmd_hs) begin
                    w_state_nxt = (cmd_in_len != '0) ? ST_LOAD : ST_RUN;
                end
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                soc_addr = r_in_base + ADDR_W'(r_idx);
                if (ld_valid) begin
                    soc_write_en = 1'b1;
                    soc_data_in  = ld_data;
                end
                if (w_last_wr) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                start = 1'b1;
                if (done) begin
                    w_state_nxt = (r_out_len != '0) ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Address stays on the word being fetched/held until its handshake.
                soc_addr = r_out_base + ADDR_W'(r_idx);
                if (w_last_rd) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // r_cmd_en keeps cmd_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_en   <= 1'b0;
            r_in_base  <= '0;
            r_out_base <= '0;
            r_in_len   <= '0;
            r_out_len  <= '0;
            r_idx      <= '0;
        end else begin
            r_cmd_en <= 1'b1;
            if (w_cmd_hs) begin
                r_in_base  <= cmd_in_base;
                r_out_base <= cmd_out_base;
                r_in_len   <= cmd_in_len;
                r_out_len  <= cmd_out_len;
            end
            if (w_state_nxt != r_state) begin
                r_idx <= '0;
            end else if (w_ld_hs || w_rd_hs) begin
                r_idx <= r_idx + LEN_W'(1);
            end
        end
    end

    mhsa_rd_buf #(
        .DATA_W (DATA_W)
    ) u_rd_buf (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_in_vld  (w_rd_issue),
        .o_in_rdy  (w_buf_rdy),
        .i_in_dat  (soc_data_out),
        .o_out_vld (rd_valid),
        .i_out_rdy (rd_ready),
        .o_out_dat (rd_data)
    );

endmodule

// File: tb/tb_mhsa_launch_ctrl.sv
// Randomized scoreboard bench for mhsa_launch_ctrl: expected writes/reads are queued per job
// from base+k arithmetic; a negedge monitor pops and compares on every write strobe and rd handshake.
module tb_mhsa_launch_ctrl;

    localparam int AW = 16;
    localparam int DW = 64;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_in_base = '0;
    logic [AW-1:0] cmd_out_base = '0;
    logic [LW-1:0] cmd_in_len = '0;
    logic [LW-1:0] cmd_out_len = '0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [DW-1:0] ld_data = '0;
    logic          start;
    logic          done = 1'b0;
    logic [AW-1:0] input_base;
    logic [AW-1:0] output_base;
    logic          soc_write_en;
    logic [AW-1:0] soc_addr;
    logic [DW-1:0] soc_data_in;
    logic [DW-1:0] soc_data_out;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } wr_t;

    wr_t           wr_q[$];
    logic [DW-1:0] rd_q[$];

    always #5 clk = ~clk;

    // SoC buffer read model: combinational, content is a fixed function of address.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {16'hA5A5, a, ~a, a ^ 16'h3C3C};
    endfunction

    assign soc_data_out = pat(soc_addr);

    mhsa_launch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_in_base(cmd_in_base), .cmd_out_base(cmd_out_base),
        .cmd_in_len(cmd_in_len), .cmd_out_len(cmd_out_len),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .start(start), .done(done),
        .input_base(input_base), .output_base(output_base),
        .soc_write_en(soc_write_en), .soc_addr(soc_addr),
        .soc_data_in(soc_data_in), .soc_data_out(soc_data_out),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or completes a read handshake.
    wr_t           mon_e;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_dat = '0;
    logic [AW-1:0] prev_addr = '0;
    int            stall_seen = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (soc_write_en) begin
                if (wr_q.size() == 0) begin
                    fail("unexpected_write");
                end else begin
                    mon_e = wr_q.pop_front();
                    chk("wr_addr", soc_addr, mon_e.addr);
                    chk("wr_data", soc_data_in, mon_e.dat);
                end
            end else if (busy) begin
                chk("wr_data_idle_zero", soc_data_in, '0);
            end
            if (rd_valid && rd_ready) begin
                if (rd_q.size() == 0) fail("unexpected_read");
                else chk("rd_data", rd_data, rd_q.pop_front());
            end
            if (rd_valid && !rd_ready) begin
                if (prev_hold) begin
                    chk("stall_rd_data", rd_data, prev_dat);
                    chk("stall_soc_addr", soc_addr, prev_addr);
                    stall_seen++;
                end
                prev_hold = 1'b1;
                prev_dat  = rd_data;
                prev_addr = soc_addr;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    task automatic run_job(input logic [AW-1:0] ib, input int il, input logic [AW-1:0] ob,
                           input int ol, input bit stall, input bit done_in_load, input bit abort);
        logic [DW-1:0] words[$];
        wr_t e;
        int  n;
        int  w;
        int  hold;
        for (int k = 0; k < il; k++) begin
            words.push_back({$urandom, $urandom});
            e.addr = ib + AW'(k);
            e.dat  = words[k];
            wr_q.push_back(e);
        end
        for (int k = 0; k < ol; k++) rd_q.push_back(pat(ob + AW'(k)));

        tick();
        cmd_valid = 1'b1; cmd_in_base = ib; cmd_out_base = ob;
        cmd_in_len = LW'(il); cmd_out_len = LW'(ol);
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (!cmd_ready) begin fail("cmd_accept_timeout"); cmd_valid = 1'b0; return; end
        tick();
        cmd_valid = 1'b0;
        cmd_in_base = AW'($urandom); cmd_out_base = AW'($urandom);
        cmd_in_len = LW'($urandom); cmd_out_len = LW'($urandom);
        @(negedge clk);
        chk("input_base_latched", input_base, ib);
        chk("output_base_latched", output_base, ob);
        chk("busy_after_accept", busy, 1);
        chk("cmd_ready_low_busy", cmd_ready, 0);
        if (il == 0) chk("start_direct_run", start, 1);
        else chk("ld_ready_in_load", ld_ready, 1);
        tick();

        if (done_in_load) begin
            done = 1'b1; tick(); done = 1'b0;
            @(negedge clk);
            chk("done_in_load_start", start, 0);
            chk("done_in_load_state", ld_ready, 1);
            tick();
        end
        for (int k = 0; k < il; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            ld_valid = 1'b1;
            ld_data  = words[k];
            n = 0;
            @(negedge clk);
            while (!ld_ready && n < 50) begin @(negedge clk); n++; end
            if (!ld_ready) fail("ld_ready_timeout");
            tick();
            ld_valid = 1'b0;
            ld_data  = {$urandom, $urandom};
        end

        n = 0;
        @(negedge clk);
        while (!start && n < 50) begin @(negedge clk); n++; end
        if (!start) begin fail("start_timeout"); return; end
        chk("ld_ready_low_in_run", ld_ready, 0);
        w = $urandom_range(0, 3);
        for (int i = 0; i < w; i++) begin
            tick();
            @(negedge clk);
            chk("start_hold", start, 1);
        end

        if (abort) begin
            @(posedge clk);
            #3 rst_n = 1'b0;
            #1;
            chk("rst_start", start, 0);
            chk("rst_busy", busy, 0);
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_input_base", input_base, 0);
            chk("rst_output_base", output_base, 0);
            chk("rst_soc_addr", soc_addr, 0);
            rd_q.delete();
            @(posedge clk);
            #3 rst_n = 1'b1;
            @(negedge clk);
            chk("rel_cmd_ready_before_edge", cmd_ready, 0);
            @(negedge clk);
            chk("rel_cmd_ready_after_edge", cmd_ready, 1);
            chk("rel_busy", busy, 0);
            return;
        end

        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        @(negedge clk);
        chk("start_fall", start, 0);
        chk("busy_after_run", busy, (ol != 0));
        chk("input_base_stable", input_base, ib);
        chk("output_base_stable", output_base, ob);

        hold = stall ? 7 : 0;
        n = 0;
        while (busy && n < 300) begin
            @(posedge clk);
            #1;
            rd_ready = (hold > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (hold > 0) hold--;
            n++;
            @(negedge clk);
        end
        if (busy) fail("drain_timeout");
        tick();
        rd_ready = 1'b0;
        @(negedge clk);
        chk("busy_low_after_job", busy, 0);
        chk("cmd_ready_after_job", cmd_ready, 1);
        chk("rd_valid_idle", rd_valid, 0);
    endtask

    initial begin
        #2;
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_start", start, 0);
        chk("reset_ld_ready", ld_ready, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_soc_we", soc_write_en, 0);
        chk("reset_soc_addr", soc_addr, 0);
        chk("reset_rd_data", rd_data, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("first_cmd_ready_pre", cmd_ready, 0);
        @(negedge clk);
        chk("first_cmd_ready", cmd_ready, 1);

        run_job(16'h0100, 4, 16'h0200, 2, 1'b0, 1'b0, 1'b0);
        run_job(16'h1234, 0, 16'h4321, 0, 1'b0, 1'b0, 1'b0);
        run_job(16'hFFFE, 3, 16'h0040, 1, 1'b0, 1'b0, 1'b0);
        stall_seen = 0;
        run_job(16'h0800, 1, 16'hFFFF, 3, 1'b1, 1'b0, 1'b0);
        checks++;
        if (stall_seen < 5) begin
            errors++;
            $display("FAIL stall_cycles: got %0d expected >=5", stall_seen);
        end
        run_job(16'h0300, 3, 16'h0500, 2, 1'b0, 1'b1, 1'b0);

        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        @(negedge clk);
        chk("done_idle_busy", busy, 0);
        chk("done_idle_start", start, 0);
        chk("done_idle_cmd_ready", cmd_ready, 1);

        run_job(16'h0A00, 2, 16'h0B00, 2, 1'b0, 1'b0, 1'b1);
        run_job(16'h0C00, 2, 16'h0D00, 3, 1'b0, 1'b0, 1'b0);

        for (int j = 0; j < 8; j++) begin
            run_job(AW'($urandom), $urandom_range(0, 5), AW'($urandom), $urandom_range(0, 4),
                    1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        chk("wr_queue_drained", wr_q.size(), 0);
        chk("rd_queue_drained", rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
